// File: rtl/exc_arbiter.sv
// MEM-stage exception/interrupt arbiter: prioritises exception flags and pending interrupts,
// drains outstanding data-bus traffic, then commits one exception to CP0 with flush and redirect.
`ifndef CP0_STATUS
`define CP0_STATUS 5'd12
`endif
`ifndef CP0_CAUSE
`define CP0_CAUSE 5'd13
`endif
`ifndef CP0_EPC
`define CP0_EPC 5'd14
`endif
`ifndef EXC_INT
`define EXC_INT 5'h10
`endif
`ifndef EXC_ADEL
`define EXC_ADEL 5'h04
`endif
`ifndef EXC_ADES
`define EXC_ADES 5'h05
`endif
`ifndef EXC_ERET
`define EXC_ERET 5'h0E
`endif

module exc_arbiter #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter logic [4:0]  CP0_STATUS_A = `CP0_STATUS,
    parameter logic [4:0]  CP0_CAUSE_A  = `CP0_CAUSE,
    parameter logic [4:0]  CP0_EPC_A    = `CP0_EPC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delayslot,
    input  logic [7:0]  mem_flags,
    input  logic [31:0] mem_addr,
    input  logic        mem_req_pending,
    input  logic        wb_cp0_we,
    input  logic [4:0]  wb_cp0_waddr,
    input  logic [31:0] wb_cp0_wdata,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    output logic [4:0]  excepttype_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] current_inst_addr_o,
    output logic [31:0] badvaddr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        stall_req_o
);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [4:0]  type_q, type_d;
    logic        ds_q, ds_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] bad_q, bad_d;
    logic [31:0] tgt_q, tgt_d;

    logic [31:0] status_eff, cause_eff, epc_eff;
    logic        int_pend, hit;
    logic [4:0]  det_type;
    logic [31:0] det_bad;

    // WB-stage mtc0 bypass; only the software-writable IP[1:0] bits of Cause are forwarded.
    always_comb begin
        status_eff = cp0_status;
        cause_eff  = cp0_cause;
        epc_eff    = cp0_epc;
        if (wb_cp0_we && wb_cp0_waddr == CP0_STATUS_A) status_eff = wb_cp0_wdata;
        if (wb_cp0_we && wb_cp0_waddr == CP0_CAUSE_A)  cause_eff[9:8] = wb_cp0_wdata[9:8];
        if (wb_cp0_we && wb_cp0_waddr == CP0_EPC_A)    epc_eff = wb_cp0_wdata;
    end

    assign int_pend = mem_valid && status_eff[0] && !status_eff[1] &&
                      (|(cause_eff[15:8] & status_eff[15:8]));
    assign hit      = int_pend || (mem_valid && (|mem_flags));

    always_comb begin
        det_type = 5'h00;
        det_bad  = 32'h0;
        if (int_pend) begin
            det_type = `EXC_INT;
        end else if (mem_valid) begin
            if (mem_flags[7]) begin
                det_type = `EXC_ADEL;
                det_bad  = mem_pc;
            end else if (mem_flags[6]) begin
                det_type = 5'h0A;
            end else if (mem_flags[5]) begin
                det_type = 5'h0C;
            end else if (mem_flags[4]) begin
                det_type = 5'h08;
            end else if (mem_flags[3]) begin
                det_type = 5'h09;
            end else if (mem_flags[2]) begin
                det_type = `EXC_ERET;
            end else if (mem_flags[1]) begin
                det_type = `EXC_ADEL;
                det_bad  = mem_addr;
            end else if (mem_flags[0]) begin
                det_type = `EXC_ADES;
                det_bad  = mem_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            type_q  <= 5'h00;
            ds_q    <= 1'b0;
            pc_q    <= 32'h0;
            bad_q   <= 32'h0;
            tgt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            ds_q    <= ds_d;
            pc_q    <= pc_d;
            bad_q   <= bad_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        type_d              = type_q;
        ds_d                = ds_q;
        pc_d                = pc_q;
        bad_d               = bad_q;
        tgt_d               = tgt_q;
        excepttype_o        = 5'h00;
        is_in_delayslot_o   = 1'b0;
        current_inst_addr_o = 32'h0;
        badvaddr_o          = 32'h0;
        flush_o             = 1'b0;
        new_pc_o            = 32'h0;
        stall_req_o         = 1'b0;
        case (state_q)
            IDLE: begin
                stall_req_o = hit;
                if (hit) begin
                    type_d  = det_type;
                    ds_d    = mem_in_delayslot;
                    pc_d    = mem_pc;
                    bad_d   = det_bad;
                    // ERET target is frozen here; later EPC writes must not move it.
                    tgt_d   = (det_type == `EXC_ERET) ? epc_eff : EXC_VECTOR;
                    state_d = mem_req_pending ? WAIT_MEM : COMMIT;
                end
            end
            WAIT_MEM: begin
                stall_req_o = 1'b1;
                if (!mem_req_pending) state_d = COMMIT;
            end
            COMMIT: begin
                excepttype_o        = type_q;
                is_in_delayslot_o   = ds_q;
                current_inst_addr_o = pc_q;
                badvaddr_o          = bad_q;
                flush_o             = 1'b1;
                new_pc_o            = tgt_q;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_exc_arbiter.sv
// Scoreboard bench for exc_arbiter: expected commits are queued at stimulus time and
// compared whenever the DUT raises flush_o.
module tb_exc_arbiter;

    localparam logic [4:0]  T_INT  = 5'h10;
    localparam logic [4:0]  T_ADEL = 5'h04;
    localparam logic [4:0]  T_ADES = 5'h05;
    localparam logic [4:0]  T_ERET = 5'h0E;
    localparam logic [4:0]  A_STAT = 5'd12;
    localparam logic [4:0]  A_CAUS = 5'd13;
    localparam logic [4:0]  A_EPC  = 5'd14;
    localparam logic [31:0] VEC    = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_pc = 32'h0;
    logic        mem_in_delayslot = 1'b0;
    logic [7:0]  mem_flags = 8'h0;
    logic [31:0] mem_addr = 32'h0;
    logic        mem_req_pending = 1'b0;
    logic        wb_cp0_we = 1'b0;
    logic [4:0]  wb_cp0_waddr = 5'h0;
    logic [31:0] wb_cp0_wdata = 32'h0;
    logic [31:0] cp0_status = 32'h0;
    logic [31:0] cp0_cause = 32'h0;
    logic [31:0] cp0_epc = 32'h0;
    logic [4:0]  excepttype_o;
    logic        is_in_delayslot_o;
    logic [31:0] current_inst_addr_o;
    logic [31:0] badvaddr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        stall_req_o;

    exc_arbiter dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_in_delayslot(mem_in_delayslot), .mem_flags(mem_flags), .mem_addr(mem_addr),
        .mem_req_pending(mem_req_pending), .wb_cp0_we(wb_cp0_we), .wb_cp0_waddr(wb_cp0_waddr),
        .wb_cp0_wdata(wb_cp0_wdata), .cp0_status(cp0_status), .cp0_cause(cp0_cause),
        .cp0_epc(cp0_epc), .excepttype_o(excepttype_o), .is_in_delayslot_o(is_in_delayslot_o),
        .current_inst_addr_o(current_inst_addr_o), .badvaddr_o(badvaddr_o), .flush_o(flush_o),
        .new_pc_o(new_pc_o), .stall_req_o(stall_req_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  etype;
        logic        ds;
        logic [31:0] pc;
        logic [31:0] bad;
        logic [31:0] npc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h t=%0t", tag, got, want, $time);
        end
    endtask

    // Commit monitor: every flush must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (flush_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_flush", {31'h0, flush_o}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("excepttype", {27'h0, excepttype_o}, {27'h0, e.etype});
                    check("delayslot", {31'h0, is_in_delayslot_o}, {31'h0, e.ds});
                    check("inst_addr", current_inst_addr_o, e.pc);
                    check("badvaddr", badvaddr_o, e.bad);
                    check("new_pc", new_pc_o, e.npc);
                    check("stall_in_commit", {31'h0, stall_req_o}, 32'h0);
                end
            end else begin
                check("idle_type", {27'h0, excepttype_o}, 32'h0);
                check("idle_new_pc", new_pc_o, 32'h0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] t, input logic ds, input logic [31:0] pc,
                        input logic [31:0] bad, input logic [31:0] npc);
        exp_t e;
        e.etype = t; e.ds = ds; e.pc = pc; e.bad = bad; e.npc = npc;
        exp_q.push_back(e);
    endtask

    // One exception with no pending bus request: stall in cycle N, commit in N+1, idle in N+2.
    task automatic run_exc(input string tag, input logic [7:0] flags, input logic [31:0] pc,
                           input logic ds, input logic [31:0] addr, input logic [4:0] t,
                           input logic [31:0] bad, input logic [31:0] npc);
        mem_valid = 1'b1; mem_flags = flags; mem_pc = pc; mem_in_delayslot = ds; mem_addr = addr;
        push(t, ds, pc, bad, npc);
        @(negedge clk);
        check({tag, "_stall"}, {31'h0, stall_req_o}, 32'h1);
        check({tag, "_noflush"}, {31'h0, flush_o}, 32'h0);
        step();
        mem_valid = 1'b0; mem_flags = 8'h0; wb_cp0_we = 1'b0;
        @(negedge clk);
        check({tag, "_commit"}, {31'h0, flush_o}, 32'h1);
        step();
        @(negedge clk);
        check({tag, "_oneshot"}, {31'h0, flush_o}, 32'h0);
        check({tag, "_drain"}, exp_q.size(), 32'h0);
        step();
    endtask

    initial begin
        step();
        @(negedge clk);
        check("rst_flush", {31'h0, flush_o}, 32'h0);
        check("rst_stall", {31'h0, stall_req_o}, 32'h0);
        check("rst_type", {27'h0, excepttype_o}, 32'h0);
        check("rst_newpc", new_pc_o, 32'h0);
        step();
        rst = 1'b0;

        run_exc("ov", 8'h20, 32'h8000_0100, 1'b0, 32'h0, 5'h0C, 32'h0, VEC);

        // adel_load held off by three cycles of bus traffic.
        mem_valid = 1'b1; mem_flags = 8'h02; mem_pc = 32'h8000_0200; mem_addr = 32'h1003;
        mem_req_pending = 1'b1;
        push(T_ADEL, 1'b0, 32'h8000_0200, 32'h1003, VEC);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_req_pending = 1'b0;
            @(negedge clk);
            check("wait_stall", {31'h0, stall_req_o}, 32'h1);
            check("wait_noflush", {31'h0, flush_o}, 32'h0);
            step();
        end
        mem_valid = 1'b0; mem_flags = 8'h0;
        @(negedge clk);
        check("wait_commit", {31'h0, flush_o}, 32'h1);
        step();
        check("wait_drain", exp_q.size(), 32'h0);

        // ERET with same-cycle EPC bypass.
        cp0_epc = 32'h100; wb_cp0_we = 1'b1; wb_cp0_waddr = A_EPC; wb_cp0_wdata = 32'h200;
        run_exc("eret_byp", 8'h04, 32'h8000_0300, 1'b0, 32'h0, T_ERET, 32'h0, 32'h200);

        // ERET target frozen at detection despite later EPC updates.
        cp0_epc = 32'h300; mem_valid = 1'b1; mem_flags = 8'h04; mem_pc = 32'h8000_0304;
        mem_req_pending = 1'b1;
        push(T_ERET, 1'b0, 32'h8000_0304, 32'h0, 32'h300);
        step();
        cp0_epc = 32'h400; wb_cp0_we = 1'b1; wb_cp0_waddr = A_EPC; wb_cp0_wdata = 32'h500;
        mem_req_pending = 1'b0;
        step();
        mem_valid = 1'b0; mem_flags = 8'h0; wb_cp0_we = 1'b0;
        @(negedge clk);
        check("eret_frozen_commit", {31'h0, flush_o}, 32'h1);
        step();
        check("eret_frozen_drain", exp_q.size(), 32'h0);

        // Interrupt versus RI, then masked by EXL, then masked by a bypassed Status write.
        cp0_status = 32'h0000_0401; cp0_cause = 32'h0000_0400;
        run_exc("int_wins", 8'h40, 32'h8000_0400, 1'b0, 32'h0, T_INT, 32'h0, VEC);
        cp0_status = 32'h0000_0403;
        run_exc("exl_mask", 8'h40, 32'h8000_0404, 1'b0, 32'h0, 5'h0A, 32'h0, VEC);
        cp0_status = 32'h0000_0401;
        wb_cp0_we = 1'b1; wb_cp0_waddr = A_STAT; wb_cp0_wdata = 32'h0;
        run_exc("stat_byp", 8'h40, 32'h8000_0408, 1'b0, 32'h0, 5'h0A, 32'h0, VEC);

        // Software interrupt raised only through a bypassed Cause write.
        cp0_status = 32'h0000_0101; cp0_cause = 32'h0;
        wb_cp0_we = 1'b1; wb_cp0_waddr = A_CAUS; wb_cp0_wdata = 32'h0000_0100;
        run_exc("cause_byp", 8'h00, 32'h8000_0500, 1'b0, 32'h0, T_INT, 32'h0, VEC);
        cp0_status = 32'h0;

        run_exc("adel_prio", 8'h92, 32'h4, 1'b0, 32'h1003, T_ADEL, 32'h4, VEC);
        run_exc("ades", 8'h01, 32'h8000_0600, 1'b0, 32'h2002, T_ADES, 32'h2002, VEC);
        run_exc("ds_sys", 8'h10, 32'h8000_0704, 1'b1, 32'h0, 5'h08, 32'h0, VEC);
        run_exc("brk", 8'h08, 32'h8000_0800, 1'b0, 32'h0, 5'h09, 32'h0, VEC);

        // Reset in WAIT_MEM drops the pending exception.
        mem_valid = 1'b1; mem_flags = 8'h02; mem_addr = 32'h3000; mem_req_pending = 1'b1;
        step();
        @(negedge clk);
        check("rstwait_stall", {31'h0, stall_req_o}, 32'h1);
        rst = 1'b1; mem_valid = 1'b0; mem_flags = 8'h0; mem_req_pending = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rstwait_flush", {31'h0, flush_o}, 32'h0);
        check("rstwait_stall0", {31'h0, stall_req_o}, 32'h0);
        check("rstwait_type", {27'h0, excepttype_o}, 32'h0);
        check("rstwait_bad", badvaddr_o, 32'h0);
        for (int i = 0; i < 3; i++) step();

        // Bubble with all flags and an enabled interrupt: nothing happens.
        cp0_status = 32'h0000_FF01; cp0_cause = 32'h0000_FF00;
        mem_valid = 1'b0; mem_flags = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bubble_stall", {31'h0, stall_req_o}, 32'h0);
            check("bubble_flush", {31'h0, flush_o}, 32'h0);
            step();
        end
        check("final_drain", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
